// File: rtl/modulo_power_ctrl.sv
// Right-to-left square-and-multiply controller for modular exponentiation.
// Issues one (a*b) mod n request at a time to an external modulo-product unit.
//
// state    | meaning
// ---------|-------------------------------------------------------------
// IDLE     | waiting for i_start; completion also returns here
// MUL_REQ  | one-cycle request res*base mod n
// MUL_WAIT | operands held, waiting for the product result into res
// SQR_REQ  | one-cycle request base*base mod n
// SQR_WAIT | operands held, waiting for the product result into base
module modulo_power_ctrl #(
    parameter int EXP_BITS = 256
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [255:0]        i_y,
    input  logic [EXP_BITS-1:0] i_d,
    input  logic [255:0]        i_n,
    output logic [255:0]        o_result,
    output logic                o_finish,
    output logic                o_busy,
    output logic                o_mp_start,
    output logic [255:0]        o_mp_a,
    output logic [256:0]        o_mp_b,
    output logic [255:0]        o_mp_n,
    input  logic [256:0]        i_mp_result,
    input  logic                i_mp_finish
);

    localparam int IDX_W = $clog2(EXP_BITS) + 1;
    localparam int SEL_W = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(EXP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_REQ,
        S_MUL_WAIT,
        S_SQR_REQ,
        S_SQR_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [255:0]        res_q, res_d;
    logic [255:0]        base_q, base_d;
    logic [EXP_BITS-1:0] d_r_q, d_r_d;
    logic [255:0]        n_r_q, n_r_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [255:0]        result_q, result_d;
    logic                finish_q, finish_d;
    logic                busy_q, busy_d;

    logic [255:0]        mp_res;
    logic                mp_res_unused;
    logic [IDX_W-1:0]    idx_inc;
    logic [SEL_W-1:0]    bit_sel;

    // The product unit returns 257 bits but the reduced value always fits in 256.
    assign mp_res        = i_mp_result[255:0];
    assign mp_res_unused = i_mp_result[256];
    assign idx_inc       = idx_q + IDX_W'(1);
    assign bit_sel       = idx_inc[SEL_W-1:0];

    always_comb begin
        state_d    = state_q;
        res_d      = res_q;
        base_d     = base_q;
        d_r_d      = d_r_q;
        n_r_d      = n_r_q;
        idx_d      = idx_q;
        result_d   = result_q;
        finish_d   = 1'b0;
        busy_d     = busy_q;
        o_mp_start = 1'b0;
        o_mp_a     = '0;
        o_mp_b     = '0;
        o_mp_n     = '0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    d_r_d  = i_d;
                    n_r_d  = i_n;
                    res_d  = 256'd1;
                    base_d = i_y;
                    idx_d  = '0;
                    busy_d = 1'b1;
                    if (i_d[0]) begin
                        state_d = S_MUL_REQ;
                    end else if (EXP_BITS == 1) begin
                        busy_d   = 1'b0;
                        finish_d = 1'b1;
                        result_d = 256'd1;
                    end else begin
                        state_d = S_SQR_REQ;
                    end
                end
            end
            S_MUL_REQ, S_MUL_WAIT: begin
                o_mp_start = (state_q == S_MUL_REQ);
                o_mp_a     = res_q;
                o_mp_b     = {1'b0, base_q};
                o_mp_n     = n_r_q;
                if (state_q == S_MUL_REQ) begin
                    state_d = S_MUL_WAIT;
                end else if (i_mp_finish) begin
                    res_d = mp_res;
                    if (idx_q == IDX_LAST) begin
                        state_d  = S_IDLE;
                        busy_d   = 1'b0;
                        finish_d = 1'b1;
                        result_d = mp_res;
                    end else begin
                        state_d = S_SQR_REQ;
                    end
                end
            end
            S_SQR_REQ, S_SQR_WAIT: begin
                o_mp_start = (state_q == S_SQR_REQ);
                o_mp_a     = base_q;
                o_mp_b     = {1'b0, base_q};
                o_mp_n     = n_r_q;
                if (state_q == S_SQR_REQ) begin
                    state_d = S_SQR_WAIT;
                end else if (i_mp_finish) begin
                    base_d = mp_res;
                    idx_d  = idx_inc;
                    if (d_r_q[bit_sel]) begin
                        state_d = S_MUL_REQ;
                    end else if (idx_inc == IDX_LAST) begin
                        // A clear top bit needs no final squaring: res is already the answer.
                        state_d  = S_IDLE;
                        busy_d   = 1'b0;
                        finish_d = 1'b1;
                        result_d = res_q;
                    end else begin
                        state_d = S_SQR_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            res_q    <= '0;
            base_q   <= '0;
            d_r_q    <= '0;
            n_r_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
            finish_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            base_q   <= base_d;
            d_r_q    <= d_r_d;
            n_r_q    <= n_r_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            finish_q <= finish_d;
            busy_q   <= busy_d;
        end
    end

    assign o_result = result_q;
    assign o_finish = finish_q;
    assign o_busy   = busy_q;

endmodule

// File: doc/modulo_power_ctrl.md
# modulo_power_ctrl

Modular-exponentiation controller for the RSA core: computes o_result = i_y^i_d mod i_n by right-to-left square-and-multiply. It computes nothing itself. It is the initiator side of the modulo-product handshake: it issues one (a·b) mod n request at a time to an external shift-add modulo-product unit and consumes each result. It sits between the Avalon/RS232 wrapper (above) and the product unit (below).

## Interface
- EXP_BITS, 256, number of exponent bits scanned (LSB first)
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  start request, sampled only in IDLE
- i_y  in  256  base; contract: i_y < i_n
- i_d  in  EXP_BITS  exponent
- i_n  in  256  modulus; contract: i_n > 1
- o_result  out  256  i_y^i_d mod i_n, valid from o_finish onward
- o_finish  out  1  one-cycle completion pulse
- o_busy  out  1  high from the accepting edge until the last product result is consumed
- o_mp_start  out  1  product request pulse
- o_mp_a  out  256  product operand a
- o_mp_b  out  257  product operand b, zero-extended
- o_mp_n  out  256  product modulus
- i_mp_result  in  257  product result; only bits [255:0] are used
- i_mp_finish  in  1  product done pulse; i_mp_result is valid in the same cycle

## Operation
- Reset values: o_result=0, o_finish=0, o_busy=0, o_mp_start=0, o_mp_a/b/n=0. State is IDLE and all internal registers are 0.
- Registers:
  - res (256): init 1
  - base (256): init i_y
  - d_r (EXP_BITS): latched i_d
  - n_r (256): latched i_n
  - idx (log2(EXP_BITS)+1 bits): init 0
- States and transitions:
  - IDLE:
    - If i_start=1: latch i_y/i_d/i_n, set res=1, base=i_y, idx=0.
    - Go to MUL_REQ if i_d[0]=1, else SQR_REQ.
  - MUL_REQ:
    - Drive o_mp_start=1, o_mp_a=res, o_mp_b={1'b0,base}, o_mp_n=n_r.
    - Go to MUL_WAIT.
  - MUL_WAIT:
    - Hold the operand outputs; o_mp_start=0.
    - On i_mp_finish: res ← i_mp_result[255:0].
    - Then go to IDLE-completion if idx=EXP_BITS-1, else SQR_REQ.
  - SQR_REQ:
    - Drive o_mp_start=1, o_mp_a=base, o_mp_b={1'b0,base}.
    - Go to SQR_WAIT.
  - SQR_WAIT:
    - On i_mp_finish: base ← i_mp_result[255:0], idx ← idx+1.
    - Next state is MUL_REQ if d_r[idx+1]=1, else SQR_REQ.
- Final bit: SQR_REQ is not entered for idx=EXP_BITS-1.
  - If d_r[EXP_BITS-1]=0, completion happens directly from SQR_WAIT of bit EXP_BITS-2.
  - If EXP_BITS=1 and d=0, completion happens straight from IDLE with res=1.
- Completion:
  - State ← IDLE, o_busy ← 0, o_result ← res (final value), o_finish ← 1 for exactly one cycle.
  - o_result holds until the next completion or reset.
- Product-call count = popcount(i_d) + (EXP_BITS−1). For example, i_d=0 with EXP_BITS=256 gives 255 squarings and result 1.
- i_mp_finish is ignored outside MUL_WAIT/SQR_WAIT, including a stale finish in a REQ cycle.
- i_start is ignored while o_busy=1.
- Operands outside contract (i_y ≥ i_n or i_n ≤ 1): result is unspecified, but the FSM still completes with the same call count.
- Reset mid-operation: all registers return to reset values immediately. The in-flight product is abandoned; its later i_mp_finish is ignored because the state is IDLE.

## Timing
- Accepting edge: i_start=1 in IDLE. The first REQ cycle is the next cycle, and o_busy=1 from that cycle.
- o_mp_start is high exactly one cycle per call (the REQ state).
- o_mp_a/b/n are stable from the REQ cycle until the cycle i_mp_finish is seen.
- With product latency L (finish seen L cycles after the start cycle), each call occupies L+1 cycles.
- After the last finish edge, o_finish is high in the next cycle, and o_busy is low in that same cycle.
- Total: o_finish rises calls·(L+1) cycles after the first REQ cycle.
- i_start asserted during the o_finish cycle is accepted (state is IDLE).

## Test plan
- Basic: behavioural product model with L=3, n=187, y=88, d=7. Required: o_result=11; 258 o_mp_start pulses; o_finish 1032 cycles after the first REQ.
- Inverse: n=187, y=11, d=23. Required: o_result=88, then o_finish for one cycle only. Then y=0, d=5: o_result=0.
- Zero exponent: d=0, y=5, n=187. Required: o_result=1, 255 calls, no MUL_REQ ever.
- Handshake robustness:
  - Product model with random L in 1..300 and spurious i_mp_finish pulses in REQ/IDLE cycles.
  - 256-bit RSA vectors (encrypt/decrypt pair) must match the software golden model.
  - Operands must be stable during every wait.
- Busy/start:
  - i_start pulsed mid-operation with different operands → ignored and result unchanged.
  - i_start in the o_finish cycle → new operation accepted, next REQ follows immediately.
- Reset: assert i_rst_n=0 at call 100 while the product is outstanding, then release. Required:
  - All outputs 0 in the reset cycle.
  - A late i_mp_finish is ignored.
  - A fresh run (n=187, y=88, d=7) returns 11.
